wb_queue: RTL
=============

Name: wb_queue

Overview:
- Writeback queue that drives the register file's single synchronous write port (we3/wa3/wd3).
- Accepts result writes from the execute/memory stages over a valid/ready handshake and buffers them in order.
- Drains one entry per cycle unless the write port is stalled.
- Provides two forwarding lookups so operand reads see values that are queued but not yet written.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all queued entries.
- in_valid  input  1  producer has a write request.
- in_ready  output  1  queue can accept; equals !full.
- in_wa  input  AW  destination register.
- in_wd  input  DW  data to write.
- wr_stall  input  1  write port is unavailable this cycle.
- we3  output  1  write enable to register file.
- wa3  output  AW  write address to register file.
- wd3  output  DW  write data to register file.
- ra1  input  AW  forwarding lookup address, port 1.
- ra2  input  AW  forwarding lookup address, port 2.
- fwd1_hit  output  1  ra1 matches a queued entry.
- fwd1_data  output  DW  data of youngest match for ra1; 0 when no hit.
- fwd2_hit  output  1  as fwd1_hit, for ra2.
- fwd2_data  output  DW  as fwd1_data, for ra2.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.

Behaviour:
- Reset (reset_n low, asynchronous): head/tail pointers=0, count=0, all entry valid bits=0; empty=1, full=0, in_ready=1, we3=0, fwd hits=0.
- Reset mid-operation: every queued entry is discarded and no write is issued.
- Enqueue: in_valid && in_ready at a rising edge writes {in_wa,in_wd} at tail; tail increments modulo DEPTH.
- Writes to register 0 complete the handshake but are discarded: no allocation, count unchanged.
- in_ready = !full, registered-state only; it has no combinational path from wr_stall or in_valid.
- Drain: we3 = !empty && !wr_stall (combinational); wa3/wd3 = head entry at all times (wa3=0, wd3=0 when empty).
- Pop happens at the edge where we3=1; head increments modulo DEPTH. Latency from enqueue to we3 is at least 1 cycle; no same-cycle pass-through.
- Simultaneous push and pop: count unchanged. When full with a pop pending, in_ready stays 0 that cycle.
- Pointer wrap: pointers wrap at DEPTH; full/empty are derived from count, never from pointer equality alone.
- Forwarding (combinational over queued entries only; in_* of the current cycle is not forwarded):
  - Hit when ra!=0 and a valid entry has matching address.
  - Youngest matching entry (closest to tail) wins.
  - The head entry being written this cycle still forwards, because the register file updates at the same edge.
- flush: at the next edge count=0 and all valid bits clear. flush has priority over enqueue and pop. we3 is still driven normally during the flush cycle.

Optional Feature:
- WBQ_COALESCE_EN defined: an enqueue whose in_wa matches the youngest valid entry overwrites that entry's data in place; no allocation, count unchanged. This is accepted even when full, so in_ready = !full || (in_valid && in_wa==youngest address).
  - Exception: if the youngest entry is the head and is popping this cycle, the request allocates normally.
- WBQ_COALESCE_EN undefined: every nonzero-address enqueue allocates a new entry; in_ready = !full.

Test Plan:
- Reset, enqueue (wa=3, wd=0xA5A5_0001), wr_stall=0 -> next cycle we3=1, wa3=3, wd3=0xA5A5_0001; following cycle empty=1, we3=0.
- Hold wr_stall=1, enqueue 4 writes to r1..r4 -> full=1, in_ready=0, we3=0; release wr_stall -> writes r1,r2,r3,r4 on 4 consecutive cycles, in order.
- Enqueue r5=0x11 then r5=0x22 with wr_stall=1; ra1=5 -> fwd1_hit=1, fwd1_data=0x22; ra2=0 -> fwd2_hit=0, fwd2_data=0.
- Enqueue wa=0, wd=0xFFFF_FFFF -> handshake completes, count stays 0, we3 never asserts.
- Queue holds 3 entries, assert flush with in_valid=1 (wa=7) -> next cycle count=0, r7 never written; deassert reset_n mid-drain -> outputs at reset values immediately.
- With WBQ_COALESCE_EN, full queue with youngest entry r9, enqueue r9=0x77 -> accepted, count stays 4, r9 later written with 0x77.

Source files
------------

// File: rtl/wb_queue_if.sv
// Writeback queue bus interface.
// Bundles the producer valid/ready handshake and the register-file write port.
//   in_valid/in_ready/in_wa/in_wd : producer -> queue enqueue handshake
//   wr_stall                      : write port unavailable this cycle
//   we3/wa3/wd3                   : queue -> register file write port
// Modports: slave (queue side), master (producer / register file side).
interface wb_queue_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_wa;
  logic [DW-1:0] in_wd;
  logic          wr_stall;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;

  modport slave (
    input  in_valid, in_wa, in_wd, wr_stall,
    output in_ready, we3, wa3, wd3
  );

  modport master (
    output in_valid, in_wa, in_wd, wr_stall,
    input  in_ready, we3, wa3, wd3
  );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue feeding the register file's single synchronous write port.
// Buffers result writes in order, drains one per cycle unless stalled, and offers
// two forwarding lookups over queued (not yet written) entries.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   flush             : synchronous clear of all queued entries (highest priority)
//   wb (slave)        : enqueue handshake + we3/wa3/wd3 write port + wr_stall
//   ra1/ra2           : forwarding lookup addresses
//   fwd*_hit/fwd*_data: youngest queued match (data 0 on miss)
//   count/empty/full  : occupancy
// Optional feature macro: WBQ_COALESCE_EN -- a write to the youngest entry's
// address overwrites that entry's data in place instead of allocating.
module wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  wb_queue_if.slave     wb,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          fwd1_hit,
  output logic [DW-1:0] fwd1_data,
  output logic          fwd2_hit,
  output logic [DW-1:0] fwd2_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [AW-1:0] wa_q  [DEPTH];
  logic [DW-1:0] wd_q  [DEPTH];
  logic          vld_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;

  logic          pop;
  logic          push_fire;
  logic          alloc;
  logic          coalesce;
  logic [PW-1:0] fidx;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Write port: head entry is presented continuously; zeroed when empty.
  assign pop    = !empty && !wb.wr_stall;
  assign wb.we3 = pop;
  assign wb.wa3 = empty ? '0 : wa_q[head_q];
  assign wb.wd3 = empty ? '0 : wd_q[head_q];

`ifdef WBQ_COALESCE_EN
  logic [PW-1:0] yidx;
  logic          y_match;
  assign yidx    = tail_q - PW'(1);
  assign y_match = !empty && (wa_q[yidx] == wb.in_wa);
  assign wb.in_ready = !full || (wb.in_valid && y_match);
  // A youngest entry that is also the head and popping now cannot be updated.
  assign coalesce = push_fire && (wb.in_wa != '0) && y_match &&
                    !((count_q == CW'(1)) && pop);
`else
  assign wb.in_ready = !full;
  assign coalesce    = 1'b0;
`endif

  assign push_fire = wb.in_valid && wb.in_ready;
  // Register 0 writes complete the handshake but are dropped.
  assign alloc     = push_fire && (wb.in_wa != '0) && !coalesce;
  assign count_d   = count_q + CW'(alloc) - CW'(pop);

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    fidx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fidx = head_q + PW'(i);
      if (vld_q[fidx] && (ra1 != '0) && (wa_q[fidx] == ra1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = wd_q[fidx];
      end
      if (vld_q[fidx] && (ra2 != '0) && (wa_q[fidx] == ra2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = wd_q[fidx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        wa_q[i]  <= '0;
        wd_q[i]  <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
      end
    end else begin
      if (alloc) begin
        wa_q[tail_q]  <= wb.in_wa;
        wd_q[tail_q]  <= wb.in_wd;
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PW'(1);
      end
`ifdef WBQ_COALESCE_EN
      if (coalesce) begin
        wd_q[yidx] <= wb.in_wd;
      end
`endif
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule
